pipeline_scoreboard: RTL and testbench
======================================

// Module: pipeline_scoreboard
// PURPOSE
//  Producer-side companion to the forwarding network. Tracks destination registers of issued
//  long-latency ops (loads, mul/div) whose results are not yet forwardable. Stalls DECODE on
//  RAW/WAW hazards against those registers and clears entries when the result completes.
//  Short ALU ops are never tracked; the bypass path covers them.
// PARAMETERS
//  NUM_REGS         32  architectural registers; index 0 is hardwired zero, never tracked
//  MAX_OUTSTANDING  4   max simultaneously pending long ops (1..NUM_REGS-1)
//  CNT_W            3   width of outstanding_count; must hold MAX_OUTSTANDING
// PORTS
//  clk                   in   1   clock, all state updates on posedge
//  rst                   in   1   synchronous, active-high reset
//  decode_valid          in   1   DECODE holds a valid instruction this cycle
//  decode_rs_index       in   5   source rs, aligned with DECODE output
//  decode_rt_index       in   5   source rt, aligned with DECODE output
//  decode_uses_rs        in   1   instruction reads rs
//  decode_uses_rt        in   1   instruction reads rt
//  decode_rd_index       in   5   destination index
//  decode_regwrite       in   1   instruction writes rd
//  decode_long_op        in   1   result arrives via the completion port, not ALU bypass
//  complete_valid        in   1   long-op result is forwardable this cycle
//  complete_rd_index     in   5   register being completed
//  stall                 out  1   hold DECODE this cycle (combinational)
//  pending_mask          out  32  registered; bit r = r has an outstanding long op
//  outstanding_count     out  CNT_W registered; number of set bits in pending_mask
//  err_spurious_complete out  1   registered 1-cycle pulse: completion matched no pending entry
// BEHAVIOUR
//  Reset: pending_mask=0, outstanding_count=0, err_spurious_complete=0. The clock edge with
//   rst high discards all issue and completion inputs.
//  cmp(r) = complete_valid & complete_rd_index==r & r!=0 (same-cycle wake-up).
//  hz(r)  = r!=0 & pending_mask[r] & !cmp(r).
//  stall = decode_valid & ( (decode_uses_rs & hz(rs))
//                         | (decode_uses_rt & hz(rt))
//                         | (decode_regwrite & hz(rd))                  -- WAW, short or long
//                         | (decode_long_op & decode_regwrite & rd!=0 & full) )
//   full = outstanding_count==MAX_OUTSTANDING & !(any cmp hitting a pending entry).
//  issue = decode_valid & !stall & decode_long_op & decode_regwrite & rd!=0.
//  Next state, per cycle:
//   - Valid completion (complete_valid & index!=0 & pending bit set): clear the bit, count-1.
//   - issue: set pending_mask[rd], count+1.
//   - Issue and completion on the same cycle, same rd: set wins, bit stays 1, count unchanged.
//   - Issue and completion on the same cycle, different regs: both applied, count unchanged.
//  Spurious completion (index 0 or bit clear): state unchanged; err_spurious_complete=1 next cycle.
//  Long ops with rd=0 or !decode_regwrite: never tracked; they never stall on full.
//  Stall does not depend on stall. No combinational path from complete_* into pending_mask;
//   only into stall.
//  Count never exceeds MAX_OUTSTANDING and never underflows. Assert both in simulation.
// STRUCTURE
//  Shared pipeline package holds: REG_IDX_W=5, REG_ZERO=5'd0, NUM_REGS.
//  Single module. Pending bits are a flat NUM_REGS vector with a one-hot set/clear decode;
//   no sub-module is needed.
// TESTING
//  1 Reset, then idle -> pending_mask=0, count=0, stall=0 for any decode inputs.
//  2 Long issue rd=8. Next cycle read rs=8 -> stall=1. Complete 8 -> stall=0 that same cycle;
//    pending_mask[8]=0 next cycle.
//  3 Long rd=8 pending, then short op rd=8 regwrite -> stall=1 (WAW). Rt=8 with uses_rt=0 -> stall=0.
//  4 Issue long rd=1,2,3,4 (MAX=4) -> count=4. Long rd=5 -> stall. Complete 2 in the same
//    cycle -> no stall, count stays 4.
//  5 Same cycle: complete 6 (pending) and issue long rd=6 -> pending_mask[6]=1, count unchanged.
//  6 Complete 9 (not pending), then complete 0 -> err pulses 1 cycle each, state unchanged.
//    Assert rst mid-run with 3 pending -> all outputs zero the next cycle.

Source files
------------

// File: rtl/pipeline_scoreboard_pkg.sv
// Shared pipeline constants for register indexing, plus a one-hot register decode helper.
package pipeline_scoreboard_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pipeline_scoreboard_if.sv
// Decode/completion inputs and scoreboard status outputs. The pipeline drives these signals
// through the master modport, and the scoreboard uses the slave modport.
interface pipeline_scoreboard_if
  import pipeline_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) ();

  logic                 decode_valid;
  logic [REG_IDX_W-1:0] decode_rs_index;
  logic [REG_IDX_W-1:0] decode_rt_index;
  logic                 decode_uses_rs;
  logic                 decode_uses_rt;
  logic [REG_IDX_W-1:0] decode_rd_index;
  logic                 decode_regwrite;
  logic                 decode_long_op;
  logic                 complete_valid;
  logic [REG_IDX_W-1:0] complete_rd_index;
  logic                 stall;
  logic [NUM_REGS-1:0]  pending_mask;
  logic [CNT_W-1:0]     outstanding_count;
  logic                 err_spurious_complete;

  modport master (
    output decode_valid, decode_rs_index, decode_rt_index, decode_uses_rs, decode_uses_rt,
    output decode_rd_index, decode_regwrite, decode_long_op, complete_valid, complete_rd_index,
    input  stall, pending_mask, outstanding_count, err_spurious_complete
  );

  modport slave (
    input  decode_valid, decode_rs_index, decode_rt_index, decode_uses_rs, decode_uses_rt,
    input  decode_rd_index, decode_regwrite, decode_long_op, complete_valid, complete_rd_index,
    output stall, pending_mask, outstanding_count, err_spurious_complete
  );

endinterface

// File: rtl/pipeline_scoreboard.sv
// Tracks destinations of in-flight long-latency ops and stalls DECODE on RAW/WAW hazards or a
// full table; a completion wakes its register in the same cycle.
module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 3
) (
  input logic                i_clk,
  input logic                i_rst,
  pipeline_scoreboard_if.slave sb_if
);

  logic [NUM_REGS-1:0] r_pending, w_pending_d;
  logic [CNT_W-1:0]    r_count, w_count_d;
  logic                r_err, w_err_d;

  logic w_cmp_valid, w_cmp_hit, w_full, w_track, w_issue, w_stall;
  logic w_hz_rs, w_hz_rt, w_hz_rd;

  // Pending and not being completed this very cycle.
  function automatic logic hazard(input logic [REG_IDX_W-1:0] idx,
                                  input logic [NUM_REGS-1:0]  pending,
                                  input logic                 cmp_valid,
                                  input logic [REG_IDX_W-1:0] cmp_idx);
    return (idx != REG_ZERO) && pending[idx] && !(cmp_valid && (cmp_idx == idx));
  endfunction

  always_comb begin
    w_cmp_valid = sb_if.complete_valid && (sb_if.complete_rd_index != REG_ZERO);
    w_cmp_hit   = w_cmp_valid && r_pending[sb_if.complete_rd_index];
    w_full      = (r_count == CNT_W'(MAX_OUTSTANDING)) && !w_cmp_hit;
    w_track     = sb_if.decode_long_op && sb_if.decode_regwrite &&
                  (sb_if.decode_rd_index != REG_ZERO);

    w_hz_rs = hazard(sb_if.decode_rs_index, r_pending, w_cmp_valid, sb_if.complete_rd_index);
    w_hz_rt = hazard(sb_if.decode_rt_index, r_pending, w_cmp_valid, sb_if.complete_rd_index);
    w_hz_rd = hazard(sb_if.decode_rd_index, r_pending, w_cmp_valid, sb_if.complete_rd_index);

    w_stall = sb_if.decode_valid && ((sb_if.decode_uses_rs && w_hz_rs) ||
                                     (sb_if.decode_uses_rt && w_hz_rt) ||
                                     (sb_if.decode_regwrite && w_hz_rd) ||
                                     (w_track && w_full));
    w_issue = sb_if.decode_valid && !w_stall && w_track;
  end

  always_comb begin
    w_pending_d = r_pending;
    w_count_d   = r_count;
    // Clear before set so a same-register issue keeps the bit.
    if (w_cmp_hit) w_pending_d = w_pending_d & ~reg_onehot(sb_if.complete_rd_index);
    if (w_issue)   w_pending_d = w_pending_d | reg_onehot(sb_if.decode_rd_index);
    if (w_issue && !w_cmp_hit)      w_count_d = r_count + CNT_W'(1);
    else if (!w_issue && w_cmp_hit) w_count_d = r_count - CNT_W'(1);
    w_err_d = sb_if.complete_valid && !w_cmp_hit;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_d;
      r_count   <= w_count_d;
      r_err     <= w_err_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (r_count <= CNT_W'(MAX_OUTSTANDING))
        else $error("outstanding_count exceeds MAX_OUTSTANDING");
      assert (!(w_cmp_hit && !w_issue && (r_count == '0)))
        else $error("outstanding_count underflow");
    end
  end
`endif

  assign sb_if.stall                 = w_stall;
  assign sb_if.pending_mask          = r_pending;
  assign sb_if.outstanding_count     = r_count;
  assign sb_if.err_spurious_complete = r_err;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard: one-cycle-per-row vector table plus hand sequences.
module tb_pipeline_scoreboard;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_scoreboard_if #(.CNT_W(3)) sb_if ();

  pipeline_scoreboard #(
    .MAX_OUTSTANDING(4),
    .CNT_W          (3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .sb_if(sb_if)
  );

  typedef struct {
    logic        dv;
    logic [4:0]  rs;
    logic        urs;
    logic [4:0]  rt;
    logic        urt;
    logic [4:0]  rd;
    logic        rw;
    logic        lng;
    logic        cv;
    logic [4:0]  cidx;
    logic        stall;
    logic [31:0] mask;
    logic [2:0]  cnt;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic dv, input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                              input logic rw, input logic lng, input logic cv,
                              input logic [4:0] cidx, input logic stall,
                              input logic [31:0] mask, input logic [2:0] cnt, input logic err);
    vec_t v;
    v.dv = dv; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.rd = rd; v.rw = rw;
    v.lng = lng; v.cv = cv; v.cidx = cidx; v.stall = stall; v.mask = mask; v.cnt = cnt;
    v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_if.decode_valid      = v.dv;
    sb_if.decode_rs_index   = v.rs;
    sb_if.decode_uses_rs    = v.urs;
    sb_if.decode_rt_index   = v.rt;
    sb_if.decode_uses_rt    = v.urt;
    sb_if.decode_rd_index   = v.rd;
    sb_if.decode_regwrite   = v.rw;
    sb_if.decode_long_op    = v.lng;
    sb_if.complete_valid    = v.cv;
    sb_if.complete_rd_index = v.cidx;
  endtask

  task automatic check_state(input string tag, input logic [31:0] mask, input logic [2:0] cnt,
                             input logic err);
    check({tag, ".mask"}, sb_if.pending_mask, mask);
    check({tag, ".cnt"}, 32'(sb_if.outstanding_count), 32'(cnt));
    check({tag, ".err"}, 32'(sb_if.err_spurious_complete), 32'(err));
  endtask

  // Drive one cycle's inputs just after an edge, check stall mid-cycle, state after the edge.
  task automatic run_cycle(input string tag, input vec_t v);
    drive(v);
    #3;
    check({tag, ".stall"}, 32'(sb_if.stall), 32'(v.stall));
    @(posedge clk);
    #1;
    check_state(tag, v.mask, v.cnt, v.err);
  endtask

  vec_t idle;
  vec_t hv;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state; any decode pattern must pass with nothing pending.
    check_state("reset", 32'h0, 3'd0, 1'b0);
    hv = mk(1, 8, 1, 8, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(hv);
    #3;
    check("reset.stall", 32'(sb_if.stall), 32'd0);
    drive(idle);
    @(posedge clk);
    #1;
    check_state("idle", 32'h0, 3'd0, 1'b0);

    //            dv rs urs rt urt rd rw lng cv cidx  stall mask   cnt err
    vecs.push_back(mk(1, 8, 1, 9, 1, 10, 1, 0, 0, 0, 0, 32'h0, 0, 0));    // short op untracked
    vecs.push_back(mk(1, 5, 1, 6, 1, 0, 1, 1, 0, 0, 0, 32'h0, 0, 0));     // long rd=0 untracked
    vecs.push_back(mk(1, 1, 1, 2, 1, 8, 1, 1, 0, 0, 0, 32'h100, 1, 0));   // issue long rd=8
    vecs.push_back(mk(1, 8, 1, 2, 0, 3, 1, 0, 0, 0, 1, 32'h100, 1, 0));   // RAW on rs=8
    vecs.push_back(mk(1, 8, 1, 2, 0, 3, 1, 0, 1, 8, 0, 32'h0, 0, 0));     // wake-up same cycle
    vecs.push_back(mk(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 32'h100, 1, 0));   // re-issue rd=8
    vecs.push_back(mk(1, 1, 1, 8, 0, 8, 1, 0, 0, 0, 1, 32'h100, 1, 0));   // WAW short rd=8
    vecs.push_back(mk(1, 1, 1, 8, 0, 9, 1, 0, 0, 0, 0, 32'h100, 1, 0));   // rt=8 unused
    vecs.push_back(mk(1, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 32'h100, 1, 0));   // rd=8 no regwrite
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 32'h0, 0, 0));     // complete 8
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 32'h6, 2, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 32'hE, 3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 32'h1E, 4, 0));    // full
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, 32'h1E, 4, 0));    // stall on full
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 1, 2, 0, 32'h3A, 4, 0));    // freed same cycle
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h3A, 4, 0));    // rd=0 ignores full
    vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 1, 1, 9, 1, 32'h3A, 4, 1));    // spurious keeps full
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h38, 3, 0));    // complete 1
    vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 32'h78, 4, 0));    // issue 6
    vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 1, 1, 6, 0, 32'h78, 4, 0));    // complete+issue 6
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 1, 3, 0, 32'hF0, 4, 0));    // complete 3, issue 7
    vecs.push_back(mk(1, 4, 1, 0, 0, 10, 1, 0, 1, 5, 1, 32'hD0, 3, 0));   // other reg wakes
    vecs.push_back(mk(1, 0, 0, 7, 1, 11, 1, 0, 0, 0, 1, 32'hD0, 3, 0));   // RAW on rt=7
    vecs.push_back(mk(0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hD0, 3, 0));    // invalid decode

    foreach (vecs[i]) run_cycle($sformatf("vec%0d", i), vecs[i]);

    // Spurious completions pulse err for exactly one cycle without touching state.
    run_cycle("spur9", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 32'hD0, 3, 1));
    run_cycle("spur9_end", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hD0, 3, 0));
    run_cycle("spur0", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hD0, 3, 1));
    run_cycle("spur0_end", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hD0, 3, 0));

    // Reset with three pending; the concurrent issue and completion must be discarded.
    hv = mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 4, 0, 0, 0, 0);
    drive(hv);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state("midrst", 32'h0, 3'd0, 1'b0);
    hv = mk(1, 4, 1, 7, 1, 6, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(hv);
    #3;
    check("midrst.stall", 32'(sb_if.stall), 32'd0);
    drive(idle);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
